// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned MIN_RATIO     = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // Number of clk cycles the pre-correction output is high for ratio n.
  function automatic int unsigned high_cycles(input int unsigned n);
    return (n % 2 == 1) ? (n + 1) / 2 : n / 2;
  endfunction

endpackage

// File: rtl/clk_div_duty_fix.sv
// Half-cycle duty correction for odd ratios: AND of the divided clock with
// a falling-edge delayed copy of itself; bypassed for even ratios.
module clk_div_duty_fix (
  input  logic clk,
  input  logic rst,
  input  logic pre_i,
  input  logic odd_i,
  output logic clk_o
);

  logic neg_q;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) neg_q <= 1'b0;
    else      neg_q <= pre_i;
  end

  assign clk_o = odd_i ? (pre_i & neg_q) : pre_i;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider with glitch-free ratio changes at period
// boundaries, a period-start strobe, and optional 50% duty on odd ratios.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter bit          DUTY50 = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_ratio,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] cur_ratio,
  output logic [1:0]       state_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic             pre_q, pre_d;
  logic             tick_q, tick_d;

  // IDLE: disabled. ARM: ratio latched, period starts on the next edge
  // (a latched ratio of 0 keeps re-sampling div_ratio). RUN: counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    pre_d   = 1'b0;
    tick_d  = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cur_d   = div_ratio;
          cnt_d   = '0;
          state_d = ST_ARM;
        end
        ST_ARM: begin
          cnt_d = '0;
          if (cur_q == '0) cur_d = div_ratio;
          else             state_d = ST_RUN;
        end
        ST_RUN: begin
          if (cnt_q == cur_q - ONE) begin
            cur_d = div_ratio;
            cnt_d = '0;
            if (div_ratio == '0) state_d = ST_ARM;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    // Outputs are registered from next-state values so they align with cnt.
    if (state_d == ST_RUN) begin
      tick_d = (cnt_d == '0);
      pre_d  = (32'(cur_d) >= MIN_RATIO) && (32'(cnt_d) < high_cycles(32'(cur_d)));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      pre_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
    end
  end

  generate
    if (DUTY50) begin : g_duty
      clk_div_duty_fix u_duty_fix (
        .clk   (clk),
        .rst   (rst),
        .pre_i (pre_q),
        .odd_i (cur_q[0]),
        .clk_o (clk_out)
      );
    end else begin : g_plain
      assign clk_out = pre_q;
    end
  endgenerate

  assign tick      = tick_q;
  assign cur_ratio = cur_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: both duty variants driven in parallel against a
// queue-based period model, checked on each clock half.
module tb_clk_div_prog;

  localparam int W = 8;

  logic         clk, rst, en;
  logic [W-1:0] div_ratio;
  logic         clk_out1, tick1, clk_out0, tick0;
  logic [W-1:0] cur1, cur0;
  logic [1:0]   st1, st0;

  int n_checks = 0;
  int n_fail   = 0;

  // Each entry is one clk cycle of a period: {ratio, position}.
  logic [15:0] exp_q[$];
  logic [15:0] cur_e;
  int          m_ratio;
  bit          m_live, m_pending;

  clk_div_prog #(.WIDTH(W), .DUTY50(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .div_ratio(div_ratio),
    .clk_out(clk_out1), .tick(tick1), .cur_ratio(cur1), .state_o(st1)
  );

  clk_div_prog #(.WIDTH(W), .DUTY50(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .div_ratio(div_ratio),
    .clk_out(clk_out0), .tick(tick0), .cur_ratio(cur0), .state_o(st0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int high_n(input int n);
    return (n % 2 == 1) ? (n + 1) / 2 : n / 2;
  endfunction

  // half = 0 for the clk-high half, 1 for the clk-low half of the cycle.
  function automatic logic exp_clk(input logic [15:0] e, input int half, input bit duty50);
    int n, pos, h;
    n   = int'(e[15:8]);
    pos = int'(e[7:0]);
    h   = 2 * pos + half;
    if (n < 2) return 1'b0;
    if (duty50 && (n % 2 == 1)) return (h >= 1) && (h <= n);
    return h < 2 * high_n(n);
  endfunction

  function automatic logic exp_tick(input logic [15:0] e);
    return (e[15:8] != 8'd0) && (e[7:0] == 8'd0);
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur_e     = '0;
    m_ratio   = 0;
    m_live    = 1'b0;
    m_pending = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs present now.
  task automatic model_edge();
    if (!rst) model_reset();
    else if (!en) begin
      exp_q.delete();
      cur_e     = '0;
      m_live    = 1'b0;
      m_pending = 1'b0;
    end else if (!m_live) begin
      m_live    = 1'b1;
      m_pending = 1'b1;
      m_ratio   = int'(div_ratio);
      cur_e     = '0;
    end else if (exp_q.size() != 0) begin
      cur_e = exp_q.pop_front();
    end else if (m_pending && m_ratio == 0) begin
      m_ratio = int'(div_ratio);
      cur_e   = '0;
    end else begin
      if (!m_pending) m_ratio = int'(div_ratio);
      m_pending = 1'b0;
      if (m_ratio == 0) begin
        m_pending = 1'b1;
        cur_e     = '0;
      end else begin
        for (int k = 0; k < m_ratio; k++) exp_q.push_back({8'(m_ratio), 8'(k)});
        cur_e = exp_q.pop_front();
      end
    end
  endtask

  task automatic check_first(input string ph);
    chk1({ph, " tick1"}, tick1, exp_tick(cur_e));
    chk1({ph, " tick0"}, tick0, exp_tick(cur_e));
    chk1({ph, " clk_out0"}, clk_out0, exp_clk(cur_e, 0, 1'b0));
    chk1({ph, " clk_out1 hi-half"}, clk_out1, exp_clk(cur_e, 0, 1'b1));
    chkw({ph, " cur_ratio1"}, cur1, 8'(m_ratio));
    chkw({ph, " cur_ratio0"}, cur0, 8'(m_ratio));
  endtask

  task automatic check_second(input string ph);
    chk1({ph, " clk_out1 lo-half"}, clk_out1, exp_clk(cur_e, 1, 1'b1));
    chk1({ph, " clk_out0 lo-half"}, clk_out0, exp_clk(cur_e, 1, 1'b0));
  endtask

  task automatic step(input string ph);
    model_edge();
    @(posedge clk); #1;
    check_first(ph);
    @(negedge clk); #1;
    check_second(ph);
  endtask

  task automatic run(input string ph, input int n);
    repeat (n) step(ph);
  endtask

  task automatic run_until(input string ph, input int n, input int pos);
    int i;
    i = 0;
    while (!(int'(cur_e[15:8]) == n && int'(cur_e[7:0]) == pos) && i < 600) begin
      step(ph);
      i++;
    end
    n_checks++;
    assert (i < 600) else begin
      n_fail++;
      $error("FAIL %s timeout: waited %0d cycles, limit 600", ph, i);
    end
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b0;
    div_ratio = '0;
    model_reset();
    #1;
    check_first("reset");
    run("reset", 3);
    rst = 1'b1;
    run("idle", 2);

    en = 1'b1;
    div_ratio = 8'd4;
    run("n4", 13);
    div_ratio = 8'd5;
    run("n5", 16);

    // Ratio change mid-period: current 6-cycle period must finish first.
    div_ratio = 8'd6;
    run_until("n6", 6, 2);
    div_ratio = 8'd3;
    run("n6to3", 12);

    // New ratio presented exactly on the wrap edge is the one taken.
    div_ratio = 8'd5;
    run_until("wrap", 5, 4);
    div_ratio = 8'd7;
    run("wrap7", 15);

    div_ratio = 8'd1;
    run("n1", 6);
    div_ratio = 8'd0;
    run("n0", 6);
    div_ratio = 8'd2;
    run("n0to2", 6);

    div_ratio = 8'd255;
    run_until("n255", 255, 0);
    run("n255", 2 * 255 + 5);

    // Asynchronous reset during the high phase of an N=8 period.
    div_ratio = 8'd8;
    run_until("n8", 8, 1);
    rst = 1'b0;
    #1;
    chk1("async_rst clk_out1", clk_out1, 1'b0);
    chk1("async_rst clk_out0", clk_out0, 1'b0);
    chk1("async_rst tick1", tick1, 1'b0);
    chkw("async_rst cur_ratio1", cur1, 8'd0);
    model_reset();
    run("rst8", 2);
    rst = 1'b1;
    run("rel8", 12);

    // Enable dropped for three cycles mid-period.
    div_ratio = 8'd4;
    run_until("n4b", 4, 1);
    en = 1'b0;
    run("en_off", 3);
    en = 1'b1;
    run("en_on", 12);

    repeat (40) begin
      if ($urandom_range(0, 9) == 0) div_ratio = 8'($urandom_range(0, 1));
      else                           div_ratio = 8'($urandom_range(2, 12));
      en = ($urandom_range(0, 7) != 0);
      run("rand", int'($urandom_range(1, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter WIDTH, default 8; width of divide ratio and internal counter.
REQ-002 Parameter DUTY50, default 1; 1 = odd ratios corrected to 50% duty, 0 = odd ratios high (N+1)/2 cycles.
REQ-003 clk  input  1  sole clock; all state on rising edge except the duty-correction flop (falling edge of clk).
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  divider enable; synchronous.
REQ-006 div_ratio  input  WIDTH  requested divide ratio N, unsigned.
REQ-007 clk_out  output  1  divided clock.
REQ-008 tick  output  1  one-clk-cycle strobe marking the start of each clk_out period.
REQ-009 cur_ratio  output  WIDTH  ratio currently in effect.

Function
REQ-010 Counter cnt SHALL count 0..cur_ratio-1 and wrap to 0; cur_ratio SHALL be loaded from div_ratio only at wrap or at enable start, so changes are glitch-free and take effect at the next period boundary.
REQ-011 HIGH(N) = floor(N/2) for even N, (N+1)/2 for odd N; clk_out (pre-correction) SHALL be high while cnt < HIGH(cur_ratio).
REQ-012 clk_out and tick SHALL be registered from next-state values: clk_out rises and tick is high in the same cycle in which cnt==0.
REQ-013 Period of clk_out SHALL equal cur_ratio clk cycles exactly for all N >= 2.
REQ-014 With DUTY50=1 and odd N >= 3, clk_out SHALL equal the AND of the pre-correction signal and its falling-edge-delayed copy: high N/2 clk periods, rising edge delayed half a clk cycle; tick unaffected.
REQ-015 With DUTY50=1 and even N, the correction path SHALL be bypassed (no half-cycle shift).
REQ-016 div_ratio == 0: divider stopped; clk_out held 0, tick 0, cnt 0; re-evaluated every cycle while stopped.
REQ-017 div_ratio == 1: clk_out held 0, tick high every cycle (strobe mode).
REQ-018 Maximum ratio 2^WIDTH-1 SHALL work with no counter overflow.
REQ-019 en low: on the next rising edge cnt <= 0, clk_out <= 0, tick <= 0; a high phase in progress is truncated (documented, accepted).
REQ-020 en rising: cur_ratio latched from div_ratio on that edge; first tick and clk_out rise on the following edge.
REQ-021 div_ratio change on the wrap cycle: the value present on that edge SHALL be the one latched.

Reset
REQ-022 rst low SHALL immediately clear cnt, clk_out, tick, correction flop to 0 and cur_ratio to 0.
REQ-023 Reset asserted mid-period SHALL abort the period; after rst release operation restarts per REQ-020 if en is high.
REQ-024 No output SHALL glitch high during or on release of reset.

Structure
REQ-025 Package clk_div_pkg SHALL hold default WIDTH, MIN_RATIO=2, and the HIGH(N) constant function.
REQ-026 Sub-module clk_div_duty_fix SHALL contain the falling-edge flop and AND gate; instantiated only when DUTY50=1.
REQ-027 Implementation SHALL have no combinational path from clk to clk_out other than inside clk_div_duty_fix.

Verification
REQ-028 WIDTH=8, N=4, en=1: clk_out 2 high/2 low, tick every 4 cycles, aligned with clk_out rise.
REQ-029 N=5, DUTY50=1: period 5 cycles, high 2.5 cycles; DUTY50=0: high 3, low 2.
REQ-030 N=6 running, div_ratio changed to 3 mid-period: current period completes 6 cycles, next period 3 cycles, no runt pulse.
REQ-031 N=1 -> tick every cycle, clk_out 0; N=0 -> tick and clk_out stay 0; N=255 -> period 255, high 128 (DUTY50=0).
REQ-032 rst pulsed low mid high phase at N=8: clk_out drops asynchronously, after release first tick one cycle after first edge with en=1.
REQ-033 en toggled low for 3 cycles at N=4: outputs 0 from next edge, restart with fresh full period on re-enable.
